collision_monitor: RTL and testbench

COLLISION_MONITOR -- requirements
Module: collision_monitor

---
 rtl/flappy_pkg.sv | 22 ++
 rtl/hit_debounce.sv | 41 ++++
 rtl/collision_monitor.sv | 171 +++++++++++++++++
 tb/tb_collision_monitor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// rtl/flappy_pkg.sv - shared state encoding, hit index codes and popcount helper
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RECOVER = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    localparam logic [2:0] HIT_IDX_GROUND = 3'd7;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/hit_debounce.sv
// rtl/hit_debounce.sv - counts consecutive hit frames and flags a qualified collision
module hit_debounce #(
    parameter int DEBOUNCE = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic FrameTick,
    input  logic Hit,
    input  logic Clear,
    output logic Qualified
);

    localparam logic [2:0] LAST = 3'(DEBOUNCE - 1);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        Qualified = 1'b0;
        if (FrameTick) begin
            if (Clear || !Hit) begin
                cnt_d = 3'd0;
            end else if (cnt_q == LAST) begin
                // Qualifying frame fires combinationally so the FSM acts on the same tick.
                Qualified = 1'b1;
                cnt_d     = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/collision_monitor.sv
// rtl/collision_monitor.sv - bird collision/lives/score FSM; COLLISION_INVULN_EN enables multi-frame grace
module collision_monitor
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES     = 2,
    parameter int LIVES         = 3,
    parameter int DEBOUNCE      = 2,
    parameter int SCORE_W       = 10,
    parameter int INVULN_FRAMES = 60
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 FrameTick,
    input  logic                 Start,
    input  logic                 BirdOn,
    input  logic [NUM_PIPES-1:0] PipeOn,
    input  logic                 GroundHit,
    input  logic [NUM_PIPES-1:0] PipePassed,
    output logic                 Status,
    output logic [1:0]           State,
    output logic [2:0]           Lives,
    output logic [SCORE_W-1:0]   Score,
    output logic [2:0]           HitIdx
);

    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_e             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [2:0]         hit_idx_q, hit_idx_d;

    logic [7:0]         pipe_hit_ext;
    logic [7:0]         passed_ext;
    logic               raw_hit;
    logic               qualified;
    logic               recover_done;
    logic [2:0]         hit_idx_now;
    logic [SCORE_W+3:0] score_sum;
    logic [SCORE_W-1:0] score_next;

    always_comb begin
        pipe_hit_ext                  = 8'd0;
        passed_ext                    = 8'd0;
        pipe_hit_ext[NUM_PIPES-1:0]   = PipeOn & {NUM_PIPES{BirdOn}};
        passed_ext[NUM_PIPES-1:0]     = PipePassed;
    end

    assign raw_hit = (|pipe_hit_ext) | GroundHit;

    // Lowest overlapping pipe wins; ground code only when no pipe overlaps.
    always_comb begin
        hit_idx_now = HIT_IDX_GROUND;
        for (int i = 7; i >= 0; i--) begin
            if (pipe_hit_ext[i]) begin
                hit_idx_now = 3'(i);
            end
        end
    end

    always_comb begin
        score_sum  = {4'd0, score_q} + (SCORE_W + 4)'(popcount8(passed_ext));
        score_next = (score_sum > {4'd0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    hit_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .Clk       (Clk),
        .Reset     (Reset),
        .FrameTick (FrameTick),
        .Hit       (raw_hit),
        .Clear     (state_q != ST_PLAY),
        .Qualified (qualified)
    );

`ifdef COLLISION_INVULN_EN
    localparam int GW = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;

    logic [GW-1:0] grace_q, grace_d;

    assign recover_done = (grace_q == GW'(INVULN_FRAMES - 1));

    always_comb begin
        grace_d = grace_q;
        if (FrameTick) begin
            if (state_q == ST_RECOVER && !recover_done) begin
                grace_d = grace_q + 1'b1;
            end else begin
                grace_d = '0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            grace_q <= '0;
        end else begin
            grace_q <= grace_d;
        end
    end
`else
    assign recover_done = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        hit_idx_d = hit_idx_q;
        if (FrameTick) begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        state_d = ST_PLAY;
                        lives_d = LIVES_INIT;
                        score_d = '0;
                    end
                end
                ST_PLAY: begin
                    if (qualified) begin
                        hit_idx_d = hit_idx_now;
                        if (lives_q > 3'd1) begin
                            lives_d = lives_q - 3'd1;
                            state_d = ST_RECOVER;
                        end else begin
                            lives_d = 3'd0;
                            state_d = ST_OVER;
                        end
                    end else begin
                        score_d = score_next;
                    end
                end
                ST_RECOVER: begin
                    score_d = score_next;
                    if (recover_done) begin
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                    if (Start) begin
                        state_d = ST_IDLE;
                        lives_d = LIVES_INIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= LIVES_INIT;
            score_q   <= '0;
            hit_idx_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign Status = (state_q != ST_OVER);
    assign State  = state_q;
    assign Lives  = lives_q;
    assign Score  = score_q;
    assign HitIdx = hit_idx_q;

endmodule

// File: tb/tb_collision_monitor.sv
// tb/tb_collision_monitor.sv - directed self-checking bench for collision_monitor
module tb_collision_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       FrameTick = 1'b0;
    logic       Start = 1'b0;
    logic       BirdOn = 1'b0;
    logic [1:0] PipeOn = 2'b00;
    logic       GroundHit = 1'b0;
    logic [1:0] PipePassed = 2'b00;

    logic       st_a, st_b, st_c;
    logic [1:0] state_a, state_b, state_c;
    logic [2:0] lives_a, lives_b, lives_c;
    logic [9:0] score_a, score_b;
    logic [3:0] score_c;
    logic [2:0] idx_a, idx_b, idx_c;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    collision_monitor #(.INVULN_FRAMES(4)) dut (
        .Clk(Clk), .Reset(Reset), .FrameTick(FrameTick), .Start(Start), .BirdOn(BirdOn),
        .PipeOn(PipeOn), .GroundHit(GroundHit), .PipePassed(PipePassed),
        .Status(st_a), .State(state_a), .Lives(lives_a), .Score(score_a), .HitIdx(idx_a)
    );

    collision_monitor #(.LIVES(1)) dut_l1 (
        .Clk(Clk), .Reset(Reset), .FrameTick(FrameTick), .Start(Start), .BirdOn(BirdOn),
        .PipeOn(PipeOn), .GroundHit(GroundHit), .PipePassed(PipePassed),
        .Status(st_b), .State(state_b), .Lives(lives_b), .Score(score_b), .HitIdx(idx_b)
    );

    collision_monitor #(.SCORE_W(4)) dut_s4 (
        .Clk(Clk), .Reset(Reset), .FrameTick(FrameTick), .Start(Start), .BirdOn(BirdOn),
        .PipeOn(PipeOn), .GroundHit(GroundHit), .PipePassed(PipePassed),
        .Status(st_c), .State(state_c), .Lives(lives_c), .Score(score_c), .HitIdx(idx_c)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic st, input logic bird, input logic [1:0] pipe,
                         input logic gnd, input logic [1:0] passed);
        Start      = st;
        BirdOn     = bird;
        PipeOn     = pipe;
        GroundHit  = gnd;
        PipePassed = passed;
        FrameTick  = 1'b1;
        @(posedge Clk);
        #1;
        FrameTick  = 1'b0;
        Start      = 1'b0;
        BirdOn     = 1'b0;
        PipeOn     = 2'b00;
        GroundHit  = 1'b0;
        PipePassed = 2'b00;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        @(posedge Clk);
        #1;
        do_reset();
        chk("rst_state", 16'(state_a), 16'd0);
        chk("rst_status", 16'(st_a), 16'd1);
        chk("rst_lives", 16'(lives_a), 16'd3);
        chk("rst_score", 16'(score_a), 16'd0);
        chk("rst_hitidx", 16'(idx_a), 16'd0);

        // Inputs without FrameTick must be ignored
        Start = 1'b1; BirdOn = 1'b1; PipeOn = 2'b11; GroundHit = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Start = 1'b0; BirdOn = 1'b0; PipeOn = 2'b00; GroundHit = 1'b0;
        chk("notick_state", 16'(state_a), 16'd0);

        frame(1, 0, 2'b00, 0, 2'b00);
        chk("start_state", 16'(state_a), 16'd1);
        chk("start_lives", 16'(lives_a), 16'd3);

        // hit / clear / hit never reaches the debounce count
        frame(0, 1, 2'b01, 0, 2'b00);
        frame(0, 0, 2'b00, 0, 2'b00);
        frame(0, 1, 2'b01, 0, 2'b00);
        chk("bounce_state", 16'(state_a), 16'd1);
        chk("bounce_lives", 16'(lives_a), 16'd3);
        frame(0, 0, 2'b00, 0, 2'b00);

        frame(0, 1, 2'b10, 0, 2'b00);
        chk("pipe1_first", 16'(lives_a), 16'd3);
        frame(0, 1, 2'b10, 0, 2'b00);
        chk("pipe1_lives", 16'(lives_a), 16'd2);
        chk("pipe1_idx", 16'(idx_a), 16'd1);
        chk("pipe1_state", 16'(state_a), 16'd2);

`ifdef COLLISION_INVULN_EN
        for (int i = 0; i < 3; i++) begin
            frame(0, 1, 2'b01, 1, 2'b00);
            chk("grace_state", 16'(state_a), 16'd2);
            chk("grace_lives", 16'(lives_a), 16'd2);
        end
        frame(0, 1, 2'b01, 1, 2'b00);
        chk("grace_end_state", 16'(state_a), 16'd1);
`else
        frame(0, 1, 2'b01, 1, 2'b00);
        chk("recover_end_state", 16'(state_a), 16'd1);
`endif
        chk("recover_lives", 16'(lives_a), 16'd2);
        frame(0, 1, 2'b01, 0, 2'b00);
        chk("post_recover_state", 16'(state_a), 16'd1);
        chk("post_recover_lives", 16'(lives_a), 16'd2);
        frame(0, 0, 2'b00, 0, 2'b00);

        frame(0, 0, 2'b00, 0, 2'b11);
        chk("score_2", 16'(score_a), 16'd2);
        frame(0, 0, 2'b00, 0, 2'b11);
        frame(0, 0, 2'b00, 0, 2'b01);
        chk("score_5", 16'(score_a), 16'd5);

        frame(0, 1, 2'b11, 0, 2'b00);
        frame(0, 1, 2'b11, 0, 2'b11);
        chk("hit_pass_score", 16'(score_a), 16'd5);
        chk("hit_pass_lives", 16'(lives_a), 16'd1);
        chk("hit_pass_idx", 16'(idx_a), 16'd0);
        chk("hit_pass_state", 16'(state_a), 16'd2);

        do_reset();
        chk("midrst_state", 16'(state_a), 16'd0);
        chk("midrst_score", 16'(score_a), 16'd0);
        chk("midrst_lives", 16'(lives_a), 16'd3);
        chk("midrst_status", 16'(st_a), 16'd1);

        // Single-life instance: ground collision ends the game
        frame(1, 0, 2'b00, 0, 2'b00);
        chk("l1_start_lives", 16'(lives_b), 16'd1);
        frame(0, 0, 2'b00, 1, 2'b00);
        frame(0, 0, 2'b00, 1, 2'b00);
        chk("l1_over_state", 16'(state_b), 16'd3);
        chk("l1_over_status", 16'(st_b), 16'd0);
        chk("l1_over_lives", 16'(lives_b), 16'd0);
        chk("l1_over_idx", 16'(idx_b), 16'd7);
        frame(0, 1, 2'b11, 1, 2'b11);
        chk("l1_frozen_state", 16'(state_b), 16'd3);
        chk("l1_frozen_score", 16'(score_b), 16'd0);
        frame(1, 0, 2'b00, 0, 2'b00);
        chk("l1_restart_state", 16'(state_b), 16'd0);
        chk("l1_restart_lives", 16'(lives_b), 16'd1);
        chk("l1_restart_status", 16'(st_b), 16'd1);

        // 4-bit score saturates
        do_reset();
        frame(1, 0, 2'b00, 0, 2'b00);
        for (int i = 0; i < 7; i++) frame(0, 0, 2'b00, 0, 2'b11);
        chk("s4_score_14", 16'(score_c), 16'd14);
        frame(0, 0, 2'b00, 0, 2'b11);
        chk("s4_score_sat", 16'(score_c), 16'd15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
